// File: rtl/lsu_req_if.sv
// +----------------------------------------------------------------------------+
// | Module  : lsu_req_if                                                       |
// | Brief   : Bundle of execute-stage op, memory bus and load writeback lines  |
// |           for the load/store request unit.                                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface lsu_req_if;
  // Execute-stage operation
  logic        op_valid;
  logic        op_rw;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] op_addr;
  logic [31:0] op_data;
  logic [4:0]  op_rd;
  logic        stall_out;

  // Memory request
  logic        mem_req;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [1:0]  mem_access_size;
  logic        mem_rw;

  // Memory response
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // Load writeback and error reporting
  logic        ld_we;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        misalign;
  logic        bus_err;

  // Load/store unit side: drives the memory bus and writeback
  modport master (
    input  op_valid, op_rw, op_size, op_signed, op_addr, op_data, op_rd,
    output stall_out,
    output mem_req, mem_address, mem_data_out, mem_access_size, mem_rw,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ld_we, ld_rd, ld_data, misalign, bus_err
  );

  // Environment side: pipeline and memory
  modport slave (
    output op_valid, op_rw, op_size, op_signed, op_addr, op_data, op_rd,
    input  stall_out,
    input  mem_req, mem_address, mem_data_out, mem_access_size, mem_rw,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ld_we, ld_rd, ld_data, misalign, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/lsu_req.sv
// +----------------------------------------------------------------------------+
// | Module  : lsu_req                                                          |
// | Brief   : Load/store request unit. Checks alignment and range, issues one  |
// |           memory request per op, waits for grant/response with timeout,    |
// |           and writes back extended load data.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_req #(
  parameter logic [31:0] ADDR_START = 32'h8002_0000,
  parameter logic [31:0] MEM_DEPTH  = 32'h0010_0000,
  parameter int          TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         rst,
  lsu_req_if.master    bus
);

  // Counter only has to hold TIMEOUT-1: the last waiting cycle is detected
  // before the increment, so a response on that cycle still wins.
  localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [32:0]        c_LIMIT    = {1'b0, ADDR_START} + {1'b0, MEM_DEPTH};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;

  // Latched operation; the address/data/size/rw latches double as the bus outputs
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic        r_rw;
  logic        r_signed;
  logic [4:0]  r_rd;

  logic        r_mem_req;
  logic        r_ld_we;
  logic [4:0]  r_ld_rd;
  logic [31:0] r_ld_data;
  logic        r_misalign;
  logic        r_bus_err;

  logic [32:0] w_bytes;
  logic [32:0] w_end;
  logic        w_misalign;
  logic        w_out_of_range;
  logic        w_accept;
  logic [31:0] w_ld_ext;
  logic        w_cnt_last;

  // Operation checks on the incoming op, evaluated in 33 bits so the end
  // address cannot wrap past the top of the 32-bit space
  always_comb begin
    w_bytes    = 33'd0;
    w_misalign = 1'b0;
    case (bus.op_size)
      2'b00:   begin w_bytes = 33'd1; w_misalign = 1'b0;                 end
      2'b01:   begin w_bytes = 33'd2; w_misalign = bus.op_addr[0];       end
      2'b10:   begin w_bytes = 33'd4; w_misalign = |bus.op_addr[1:0];    end
      default: begin w_bytes = 33'd0; w_misalign = 1'b1;                 end
    endcase
    w_end          = {1'b0, bus.op_addr} + w_bytes;
    w_out_of_range = (bus.op_addr < ADDR_START) || (w_end > c_LIMIT);
  end

  assign w_accept   = (r_state == S_IDLE) && bus.op_valid && !w_misalign && !w_out_of_range;
  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  // Load data extension by latched size and signedness
  always_comb begin
    w_ld_ext = bus.mem_rdata;
    case (r_size)
      2'b00:   w_ld_ext = {{24{r_signed & bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
      2'b01:   w_ld_ext = {{16{r_signed & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      default: w_ld_ext = bus.mem_rdata;
    endcase
  end

  // Request/response state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_size     <= 2'b00;
      r_rw       <= 1'b1;
      r_signed   <= 1'b0;
      r_rd       <= 5'd0;
      r_mem_req  <= 1'b0;
      r_ld_we    <= 1'b0;
      r_ld_rd    <= 5'd0;
      r_ld_data  <= 32'd0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ld_we    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.op_valid) begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
            end else if (w_out_of_range) begin
              r_bus_err <= 1'b1;
            end else begin
              r_addr    <= bus.op_addr;
              r_data    <= bus.op_data;
              r_size    <= bus.op_size;
              r_rw      <= bus.op_rw;
              r_signed  <= bus.op_signed;
              r_rd      <= bus.op_rd;
              r_mem_req <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= r_rw ? S_RESP : S_IDLE;
          end else if (w_cnt_last) begin
            r_mem_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.mem_rvalid) begin
            r_ld_data <= w_ld_ext;
            r_ld_rd   <= r_rd;
            r_ld_we   <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_cnt_last) begin
            r_bus_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall_out       = (r_state != S_IDLE) || w_accept;
  assign bus.mem_req         = r_mem_req;
  assign bus.mem_address     = r_addr;
  assign bus.mem_data_out    = r_data;
  assign bus.mem_access_size = r_size;
  assign bus.mem_rw          = r_rw;
  assign bus.ld_we           = r_ld_we;
  assign bus.ld_rd           = r_ld_rd;
  assign bus.ld_data         = r_ld_data;
  assign bus.misalign        = r_misalign;
  assign bus.bus_err         = r_bus_err;

endmodule

`default_nettype wire
